// File: rtl/display_scan_controller_pkg.sv
// rtl/display_scan_controller_pkg.sv - shared types, constants and digit helpers for the scan controller
package display_scan_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam int         NUM_DIGITS = 4;
    localparam logic [3:0] ANODES_OFF = 4'b1111;

    function automatic logic [3:0] get_nibble(input logic [15:0] v, input logic [1:0] k);
        return v[{k, 2'b00} +: 4];
    endfunction

    // A digit above digit 0 is dark when it and every more significant nibble are zero.
    function automatic logic digit_blanked(input logic [15:0] v, input logic [1:0] k, input logic blz);
        return blz && (k != 2'd0) && ((v >> {k, 2'b00}) == 16'h0000);
    endfunction

endpackage

// File: rtl/display_scan_controller_if.sv
// rtl/display_scan_controller_if.sv - request and display-drive signals of the scan controller
interface display_scan_controller_if;
    logic        disp_on;
    logic        load;
    logic [15:0] value;
    logic        blank_lz;
    logic [3:0]  dec_in;
    logic        dec_en;
    logic [3:0]  an_n;
    logic        load_ack;

    modport master (
        output disp_on, load, value, blank_lz,
        input  dec_in, dec_en, an_n, load_ack
    );

    modport slave (
        input  disp_on, load, value, blank_lz,
        output dec_in, dec_en, an_n, load_ack
    );
endinterface

// File: rtl/display_scan_controller_scan_timer.sv
// rtl/display_scan_controller_scan_timer.sv - phase counter with terminal-count pulse for SHOW/GAP
module scan_timer #(
    parameter int SHOW_CYCLES = 1000,
    parameter int GAP_CYCLES  = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic sel_gap,
    output logic tc
);
    localparam int MAXC = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] SHOW_LAST = CW'(SHOW_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Wrapping on tc restarts the count exactly when the controller changes phase.
    assign tc = !clear && (cnt == (sel_gap ? GAP_LAST : SHOW_LAST));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clear || tc)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end
endmodule

// File: rtl/display_scan_controller.sv
// rtl/display_scan_controller.sv - four-digit multiplexed display scanner with frame-aligned value updates
module display_scan_controller
    import display_scan_controller_pkg::*;
#(
    parameter int SHOW_CYCLES = 1000,
    parameter int GAP_CYCLES  = 50
) (
    input  logic                      clk,
    input  logic                      rst,
    display_scan_controller_if.slave  bus
);
    state_t      state;
    logic [1:0]  dig;
    logic [15:0] disp_reg;
    logic [15:0] pending;
    logic        pend;
    logic        valid;
    logic        load_ack_q;
    logic        tc;
    logic        boundary;
    logic        blanked;
    logic [3:0]  an_n_d;
    logic        dec_en_d;
    logic [3:0]  dec_in_d;

    scan_timer #(
        .SHOW_CYCLES (SHOW_CYCLES),
        .GAP_CYCLES  (GAP_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == ST_IDLE),
        .sel_gap (state == ST_GAP),
        .tc      (tc)
    );

    assign boundary = (state == ST_GAP) && (dig == 2'd3) && tc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            dig        <= 2'd0;
            disp_reg   <= 16'h0000;
            pending    <= 16'h0000;
            pend       <= 1'b0;
            valid      <= 1'b0;
            load_ack_q <= 1'b0;
        end else begin
            load_ack_q <= 1'b0;
            // The display register only moves outside a frame or exactly at its boundary.
            if (bus.load && (state == ST_IDLE || !valid || boundary)) begin
                disp_reg   <= bus.value;
                valid      <= 1'b1;
                pend       <= 1'b0;
                load_ack_q <= 1'b1;
            end else if (bus.load) begin
                pending <= bus.value;
                pend    <= 1'b1;
            end else if (boundary && pend) begin
                disp_reg   <= pending;
                pend       <= 1'b0;
                load_ack_q <= 1'b1;
            end

            if (!bus.disp_on) begin
                state <= ST_IDLE;
                dig   <= 2'd0;
            end else begin
                case (state)
                    ST_IDLE: if (valid) begin
                        state <= ST_SHOW;
                        dig   <= 2'd0;
                    end
                    ST_SHOW: if (tc) state <= ST_GAP;
                    ST_GAP: if (tc) begin
                        state <= ST_SHOW;
                        dig   <= dig + 2'd1;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Drive signals decode from registered state only; blank_lz is the one live input.
    always_comb begin
        an_n_d   = ANODES_OFF;
        dec_en_d = 1'b0;
        dec_in_d = 4'h0;
        blanked  = digit_blanked(disp_reg, dig, bus.blank_lz);
        if (state != ST_IDLE)
            dec_in_d = get_nibble(disp_reg, dig);
        if (state == ST_SHOW && !blanked) begin
            an_n_d   = ~(4'b0001 << dig);
            dec_en_d = 1'b1;
        end
    end

    assign bus.an_n     = an_n_d;
    assign bus.dec_en   = dec_en_d;
    assign bus.dec_in   = dec_in_d;
    assign bus.load_ack = load_ack_q;
endmodule

// File: tb/tb_display_scan_controller.sv
// tb/tb_display_scan_controller.sv - directed and randomized checks of the scan controller against a frame model
module tb_display_scan_controller;
    import display_scan_controller_pkg::*;

    localparam int S     = 4;
    localparam int G     = 2;
    localparam int FRAME = NUM_DIGITS * (S + G);

    logic clk = 1'b0;
    logic rst = 1'b1;
    display_scan_controller_if bus();

    display_scan_controller #(.SHOW_CYCLES(S), .GAP_CYCLES(G)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          pos     = 0;
    logic [15:0] disp_m  = 16'h0;
    logic [15:0] pendv_m = 16'h0;
    bit          pend_m  = 1'b0;
    bit          ack_m   = 1'b0;
    logic [15:0] v_idle;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected {an_n, dec_en, dec_in} at frame position t for displayed value v.
    function automatic logic [8:0] model_out(input int t, input logic [15:0] v, input logic blz);
        int          d     = t / (S + G);
        int          off   = t % (S + G);
        logic [15:0] upper = v >> (4 * d);
        logic [3:0]  one   = 4'h1;
        logic [3:0]  an    = 4'hF;
        logic        en    = 1'b0;
        if (off < S && !(blz && d > 0 && upper == 16'h0)) begin
            an = ~(one << d);
            en = 1'b1;
        end
        return {an, en, upper[3:0]};
    endfunction

    function automatic logic [15:0] rand_val();
        logic [15:0] m;
        case ($urandom_range(0, 4))
            0: m = 16'hFFFF;
            1: m = 16'h0FFF;
            2: m = 16'h00FF;
            3: m = 16'h000F;
            default: m = 16'h0000;
        endcase
        return 16'($urandom) & m;
    endfunction

    // One scanning cycle: compare against the model, optionally load, advance the model.
    task automatic cycle(input bit do_load, input logic [15:0] v);
        logic [8:0] e;
        e = model_out(pos, disp_m, bus.blank_lz);
        check($sformatf("an_n@%0d", pos), {12'h0, bus.an_n}, {12'h0, e[8:5]});
        check($sformatf("dec_en@%0d", pos), {15'h0, bus.dec_en}, {15'h0, e[4]});
        check($sformatf("dec_in@%0d", pos), {12'h0, bus.dec_in}, {12'h0, e[3:0]});
        check($sformatf("load_ack@%0d", pos), {15'h0, bus.load_ack}, {15'h0, ack_m});
        bus.load  = do_load;
        bus.value = v;
        tick();
        bus.load = 1'b0;
        ack_m = 1'b0;
        if (pos == FRAME - 1) begin
            if (do_load) begin
                disp_m = v; pend_m = 1'b0; ack_m = 1'b1;
            end else if (pend_m) begin
                disp_m = pendv_m; pend_m = 1'b0; ack_m = 1'b1;
            end
        end else if (do_load) begin
            pend_m = 1'b1; pendv_m = v;
        end
        pos = (pos + 1) % FRAME;
    endtask

    task automatic run_to(input int p);
        while (pos != p) cycle(1'b0, 16'h0);
    endtask

    initial begin
        bus.disp_on = 1'b0; bus.load = 1'b0; bus.value = 16'h0; bus.blank_lz = 1'b0;
        tick(); tick();
        check("rst_an_n", {12'h0, bus.an_n}, 16'h000F);
        check("rst_dec_en", {15'h0, bus.dec_en}, 16'h0);
        check("rst_dec_in", {12'h0, bus.dec_in}, 16'h0);
        check("rst_load_ack", {15'h0, bus.load_ack}, 16'h0);
        rst = 1'b0;
        bus.disp_on = 1'b1;
        repeat (4) begin
            tick();
            check("idle_an_n", {12'h0, bus.an_n}, 16'h000F);
            check("idle_dec_en", {15'h0, bus.dec_en}, 16'h0);
        end

        // First load in IDLE, then one full frame of 1234.
        bus.load = 1'b1; bus.value = 16'h1234;
        tick();
        bus.load = 1'b0;
        check("first_ack", {15'h0, bus.load_ack}, 16'h1);
        check("first_ack_an_n", {12'h0, bus.an_n}, 16'h000F);
        tick();
        pos = 0; disp_m = 16'h1234; pend_m = 1'b0; ack_m = 1'b0;
        check("first_d0_an_n", {12'h0, bus.an_n}, 16'h000E);
        check("first_d0_dec_in", {12'h0, bus.dec_in}, 16'h0004);
        repeat (FRAME) cycle(1'b0, 16'h0);

        // Two mid-frame loads: only the last one lands at the boundary.
        run_to(3);  cycle(1'b1, 16'hABCD);
        run_to(10); cycle(1'b1, 16'h00F0);
        run_to(0);
        repeat (FRAME) cycle(1'b0, 16'h0);

        // Load coincident with the frame boundary bypasses the pending register.
        run_to(FRAME - 1); cycle(1'b1, 16'h5A5A);
        repeat (FRAME) cycle(1'b0, 16'h0);

        // Leading-zero suppression of 0007.
        bus.blank_lz = 1'b1; #1;
        cycle(1'b1, 16'h0007);
        run_to(0);
        check("blz_d0_en", {15'h0, bus.dec_en}, 16'h1);
        run_to(6);
        check("blz_d1_an_n", {12'h0, bus.an_n}, 16'h000F);
        check("blz_d1_dec_en", {15'h0, bus.dec_en}, 16'h0);
        run_to(0);

        for (int it = 0; it < 8; it++) begin
            bus.blank_lz = 1'($urandom_range(0, 1)); #1;
            for (int t = 0; t < FRAME; t++)
                cycle($urandom_range(0, 5) == 0, rand_val());
        end

        // disp_on drop in SHOW, then restore at digit 0 with the same value.
        bus.blank_lz = 1'b0; #1;
        run_to(2);
        bus.disp_on = 1'b0;
        tick();
        check("off_an_n", {12'h0, bus.an_n}, 16'h000F);
        check("off_dec_en", {15'h0, bus.dec_en}, 16'h0);
        check("off_dec_in", {12'h0, bus.dec_in}, 16'h0);
        repeat (3) begin
            tick();
            check("off_hold_an_n", {12'h0, bus.an_n}, 16'h000F);
        end
        bus.disp_on = 1'b1;
        tick();
        pos = 0; ack_m = 1'b0;
        repeat (FRAME) cycle(1'b0, 16'h0);

        // Load accepted while blanked goes straight to the display register.
        run_to(8);
        bus.disp_on = 1'b0;
        tick();
        v_idle = rand_val();
        bus.load = 1'b1; bus.value = v_idle;
        tick();
        bus.load = 1'b0;
        check("idle_load_ack", {15'h0, bus.load_ack}, 16'h1);
        check("idle_load_an_n", {12'h0, bus.an_n}, 16'h000F);
        disp_m = v_idle; pend_m = 1'b0;
        bus.disp_on = 1'b1;
        tick();
        pos = 0; ack_m = 1'b0;
        repeat (FRAME) cycle(1'b0, 16'h0);

        // Asynchronous reset mid-SHOW with a value pending.
        run_to(1);
        cycle(1'b1, 16'hBEEF);
        #3 rst = 1'b1;
        #1;
        check("arst_an_n", {12'h0, bus.an_n}, 16'h000F);
        check("arst_dec_en", {15'h0, bus.dec_en}, 16'h0);
        check("arst_dec_in", {12'h0, bus.dec_in}, 16'h0);
        check("arst_load_ack", {15'h0, bus.load_ack}, 16'h0);
        tick(); tick();
        rst = 1'b0;
        repeat (30) begin
            tick();
            check("post_rst_an_n", {12'h0, bus.an_n}, 16'h000F);
            check("post_rst_load_ack", {15'h0, bus.load_ack}, 16'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/display_scan_controller.md
DISPLAY_SCAN_CONTROLLER -- requirements
Module: display_scan_controller

Interface
REQ-001 Parameter SHOW_CYCLES, default 1000, clock cycles each digit is driven.
REQ-002 Parameter GAP_CYCLES, default 50, blank dead-time cycles between digits (anti-ghosting); legal minimum 1.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 disp_on  input  1  1 = scanning permitted; 0 = display forced blank.
REQ-006 load  input  1  one-cycle request to display value.
REQ-007 value  input  16  four hex digits; digit 0 = value[3:0], digit 3 = value[15:12].
REQ-008 blank_lz  input  1  1 = suppress leading zero digits; digit 0 is never suppressed.
REQ-009 dec_in  output  4  nibble driven to the seven-segment decoder input.
REQ-010 dec_en  output  1  decoder enable; 0 forces all segments off.
REQ-011 an_n  output  4  active-low digit anodes, at most one low.
REQ-012 load_ack  output  1  one-cycle pulse: requested value now in the display register.

Function
REQ-013 States: IDLE, SHOW, GAP; digit index dig[1:0]; cycle counter cnt sized for max(SHOW_CYCLES, GAP_CYCLES).
REQ-014 IDLE: an_n=4'b1111, dec_en=0, dec_in=0; leave to SHOW with dig=0, cnt=0 when disp_on=1 and the display register is valid (at least one load accepted since reset).
REQ-015 SHOW: an_n[dig]=0, others 1; dec_in=disp_reg nibble dig; dec_en=1 unless that digit is blanked (REQ-019), then dec_en=0 and an_n=4'b1111.
REQ-016 SHOW lasts exactly SHOW_CYCLES cycles, then GAP with cnt=0.
REQ-017 GAP: an_n=4'b1111, dec_en=0, dec_in holds; lasts exactly GAP_CYCLES cycles, then SHOW with dig=dig+1 (3 wraps to 0).
REQ-018 Frame boundary = final GAP cycle with dig=3; frame length = 4*(SHOW_CYCLES+GAP_CYCLES).
REQ-019 Digit k (k>=1) is blanked when blank_lz=1 and disp_reg nibbles k..3 are all zero; blank_lz is sampled combinationally.
REQ-020 Load in IDLE, or the first load after reset: disp_reg <= value next edge; load_ack=1 the following cycle.
REQ-021 Load while scanning: value goes to pending register, pend=1; disp_reg never changes mid-frame.
REQ-022 At frame boundary with pend=1: disp_reg <= pending, pend <= 0; load_ack pulses the next cycle.
REQ-023 Load while pend=1: pending overwritten, only the last value is applied, exactly one load_ack.
REQ-024 Load in the frame-boundary cycle: value itself is written to disp_reg (bypass), pend cleared, one load_ack.
REQ-025 disp_on=0 in any state: next cycle IDLE, outputs per REQ-014; disp_reg and pending retained; loads still accepted and acknowledged (IDLE rules).
REQ-026 Outputs are registered; no combinational path from load, value or disp_on to an_n or dec_en.

Reset
REQ-027 rst=1 immediately, without clock: state=IDLE, dig=0, cnt=0, disp_reg=0, pending=0, pend=0, valid=0, an_n=4'b1111, dec_en=0, dec_in=0, load_ack=0.
REQ-028 Reset mid-frame discards pending values; no load_ack issued for them.
REQ-029 After rst falls, IDLE until the next load.

Structure
REQ-030 Shared package holds state encoding (IDLE/SHOW/GAP), NUM_DIGITS=4, ANODES_OFF=4'b1111.
REQ-031 One sub-module, scan_timer: counter with terminal-count pulse, cleared on state change.
REQ-032 The seven-segment decoder is instantiated at top level; this block does not contain it.

Verification (SHOW_CYCLES=4, GAP_CYCLES=2)
REQ-033 Reset, load value=16'h1234, disp_on=1 -> load_ack 1 cycle later; an_n cycles 1110,1111,1101,1111,1011,1111,0111,1111 with dec_in 4,3,2,1, each SHOW 4 cycles, GAP 2 cycles.
REQ-034 Mid-frame load 16'hABCD then 16'h00F0 -> display stays 1234 until boundary, then 00F0; exactly one load_ack.
REQ-035 value=16'h0007, blank_lz=1 -> dec_en=1 only for digit 0; digits 1-3 an_n=4'b1111, dec_en=0.
REQ-036 disp_on drops in SHOW -> next cycle an_n=4'b1111, dec_en=0; restore -> resumes at digit 0, same value.
REQ-037 rst asserted mid-SHOW between clock edges -> outputs at reset values before next edge; no display until a new load.
REQ-038 Load coincident with frame boundary -> new value shown on digit 0 of the next frame, single load_ack.
